uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side byte buffer directly downstream of the UART receiver. Captures each
//  received byte, together with its framing-error flag, on the receiver's one-cycle
//  done strobe. Holds up to DEPTH entries until the host side pops them.
//  Presents the head entry first-word-fall-through (FWFT), with full/empty/count status
//  and sticky overflow/underflow flags.
// PARAMETERS
//  DATAWIDTH  8   width of each received data word (matches receiver dout)
//  DEPTH      16  number of entries; power of two, >= 2
//  ADDR_W     4   pointer width, must equal log2(DEPTH)
// PORTS
//  clk        in   1            system clock, all logic on rising edge
//  rx_rst     in   1            synchronous, active-high reset
//  wr_en      in   1            write strobe; driven by receiver rx_done (1-cycle pulse)
//  din        in   DATAWIDTH    received byte; driven by receiver dout, sampled when wr_en=1
//  din_err    in   1            framing error; driven by receiver rx_error, sampled with din
//  rd_en      in   1            pop request from consumer
//  dout       out  DATAWIDTH    head-of-queue data, valid whenever empty=0
//  dout_err   out  1            framing-error flag stored with the head entry
//  empty      out  1            1 when count==0
//  full       out  1            1 when count==DEPTH
//  count      out  ADDR_W+1     number of stored entries, 0..DEPTH
//  overflow   out  1            sticky: a write was dropped because the FIFO was full
//  underflow  out  1            sticky: rd_en was asserted while the FIFO was empty
//  clr_flags  in   1            1-cycle clear of the overflow and underflow flags
// BEHAVIOUR
//  Reset (rx_rst=1 at a clk edge):
//   - wr_ptr=rd_ptr=0, count=0, empty=1, full=0, overflow=underflow=0.
//   - Storage array is not cleared. dout/dout_err are don't-care while empty=1.
//   - Reset wins over every other input in the same cycle.
//   - Reset mid-operation discards all entries; no partial state remains.
//  Storage and status:
//   - Storage is a DEPTH x (DATAWIDTH+1) register array; each entry is {din_err, din}.
//   - Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0.
//   - count is a registered counter; empty and full decode combinationally from count.
//  Output timing:
//   - dout/dout_err = mem[rd_ptr] (combinational read, FWFT).
//   - The first byte is visible the cycle after the edge that wrote it.
//  Write/read acceptance (evaluated each edge, rx_rst=0):
//   - do_wr = wr_en & (~full | rd_en); do_rd = rd_en & ~empty.
//   - do_wr: mem[wr_ptr] <= {din_err,din}; wr_ptr <= wr_ptr+1.
//   - do_rd: rd_ptr <= rd_ptr+1.
//   - count: +1 if do_wr & ~do_rd; -1 if do_rd & ~do_wr; unchanged if both or neither.
//  Boundary cases:
//   - Full with wr_en & rd_en: pop and push in the same cycle; count stays DEPTH; no overflow.
//   - Full with wr_en & ~rd_en: write dropped; overflow <= 1; pointers unchanged.
//   - Empty with rd_en (with or without wr_en): read ignored; underflow <= 1.
//     If wr_en is also high, the write is still accepted.
//   - Flag clear: clr_flags clears both sticky flags.
//     If a new overflow/underflow event occurs in the same cycle, the set wins.
//  No state machine: behaviour is pointer/counter based.
//   - wr_en pulses are at most 1 per byte time; back-to-back wr_en on consecutive cycles
//     must still be handled.
// TESTING
//  1 Reset, then write 0xA5 (err=0) -> next cycle empty=0, count=1, dout=0xA5, dout_err=0.
//  2 Write 0x11,0x22,0x33 back-to-back, then pop x3 -> dout sequence 0x11,0x22,0x33;
//    empty=1 after the last pop; count returns to 0.
//  3 Fill 16 entries (0x00..0x0F), write 0xFF -> full=1, overflow=1, count=16;
//    popping yields 0x00..0x0F, with 0xFF absent.
//  4 Full, assert wr_en(0x80) and rd_en in the same cycle -> count stays 16, overflow=0,
//    and 0x80 appears after 0x0F; pointer wrap is exercised.
//  5 Write 0x5A with din_err=1 -> dout_err=1 at head; rd_en on empty -> underflow=1;
//    clr_flags -> both flags 0 next cycle.
//  6 Hold rx_rst for 1 cycle with count=5 -> count=0, empty=1, flags 0;
//    a subsequent write of 0x3C is read back correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: first-word-fall-through FIFO
// storing {framing_error, data} per entry, with count/full/empty and sticky error flags.
module uart_rx_fifo #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4
) (
  input  logic                 clk,
  input  logic                 rx_rst,
  input  logic                 wr_en,
  input  logic [DATAWIDTH-1:0] din,
  input  logic                 din_err,
  input  logic                 rd_en,
  input  logic                 clr_flags,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 dout_err,
  output logic                 empty,
  output logic                 full,
  output logic [ADDR_W:0]      count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [DATAWIDTH:0]  mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic                do_wr;
  logic                do_rd;
  logic                ovf_event;
  logic                unf_event;

  assign empty = (count == '0);
  assign full  = (count == COUNT_FULL);

  // A full FIFO still accepts a write when a pop frees the head slot in the same cycle.
  assign do_wr     = wr_en & (~full | rd_en);
  assign do_rd     = rd_en & ~empty;
  assign ovf_event = wr_en & full & ~rd_en;
  assign unf_event = rd_en & empty;

  assign {dout_err, dout} = mem[rd_ptr];

  // Storage is deliberately left out of reset; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (!rx_rst && do_wr) begin
      mem[wr_ptr] <= {din_err, din};
    end
  end

  always_ff @(posedge clk) begin
    if (rx_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + ADDR_W'(1);

      case ({do_wr, do_rd})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase

      // A new event in the same cycle as a clear keeps the flag set.
      if (ovf_event)      overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;

      if (unf_event)      underflow <= 1'b1;
      else if (clr_flags) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed vector table plus fill/wrap/reset sequences and a
// random phase, all checked against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rx_rst;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          din_err;
  logic          rd_en;
  logic          clr_flags;
  logic [DW-1:0] dout;
  logic          dout_err;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  uart_rx_fifo #(.DATAWIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rx_rst(rx_rst), .wr_en(wr_en), .din(din), .din_err(din_err),
    .rd_en(rd_en), .clr_flags(clr_flags), .dout(dout), .dout_err(dout_err),
    .empty(empty), .full(full), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW:0] sb_q[$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;

  typedef struct {
    bit          rst;
    bit          wr;
    logic [7:0]  data;
    bit          err;
    bit          rd;
    bit          clr;
    int          exp_count;
    bit          exp_ovf;
    bit          exp_unf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, update the model at the edge, compare #1 after it.
  task automatic step(input bit rst, input bit wr, input logic [7:0] d, input bit e,
                      input bit rd, input bit clr);
    bit m_full, m_empty, m_do_wr, m_do_rd;
    @(negedge clk);
    rx_rst = rst; wr_en = wr; din = d; din_err = e; rd_en = rd; clr_flags = clr;
    m_full  = (sb_q.size() == DEPTH);
    m_empty = (sb_q.size() == 0);
    m_do_wr = wr && (!m_full || rd);
    m_do_rd = rd && !m_empty;
    @(posedge clk);
    if (rst) begin
      sb_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (m_do_rd) void'(sb_q.pop_front());
      if (m_do_wr) sb_q.push_back({e, d});
      if (wr && m_full && !rd) m_ovf = 1'b1;
      else if (clr)            m_ovf = 1'b0;
      if (rd && m_empty)       m_unf = 1'b1;
      else if (clr)            m_unf = 1'b0;
    end
    #1;
    chk("count", int'(count), sb_q.size());
    chk("empty", int'(empty), int'(sb_q.size() == 0));
    chk("full", int'(full), int'(sb_q.size() == DEPTH));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_unf));
    if (sb_q.size() != 0) chk("head", int'({dout_err, dout}), int'(sb_q[0]));
  endtask

  initial begin
    rx_rst = 1'b1; wr_en = 1'b0; din = '0; din_err = 1'b0; rd_en = 1'b0; clr_flags = 1'b0;

    //            rst wr  data   err rd clr cnt ovf unf
    vecs.push_back('{1, 0, 8'h00, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 8'hA5, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 8'h00, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 8'h11, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 1, 8'h22, 0, 0, 0, 2, 0, 0});
    vecs.push_back('{0, 1, 8'h33, 0, 0, 0, 3, 0, 0});
    vecs.push_back('{0, 0, 8'h00, 0, 1, 0, 2, 0, 0});
    vecs.push_back('{0, 0, 8'h00, 0, 1, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 8'h00, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 8'h5A, 1, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 8'h00, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 8'h00, 0, 1, 0, 0, 0, 1});
    vecs.push_back('{0, 0, 8'h00, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 1, 8'h77, 0, 1, 0, 1, 0, 1});
    vecs.push_back('{0, 0, 8'h00, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 8'h00, 0, 1, 1, 0, 0, 1});
    vecs.push_back('{0, 0, 8'h00, 0, 0, 1, 0, 0, 0});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].data, vecs[i].err, vecs[i].rd, vecs[i].clr);
      chk($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
      chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d_unf", i), int'(underflow), int'(vecs[i].exp_unf));
    end

    // Fill, overflow on a dropped write, then drain.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(i), 0, 0, 0);
    step(0, 1, 8'hFF, 0, 0, 0);
    chk("fill_full", int'(full), 1);
    chk("fill_ovf", int'(overflow), 1);
    chk("fill_count", int'(count), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_data", int'(dout), i);
      step(0, 0, 8'h00, 0, 1, 0);
    end
    chk("drain_empty", int'(empty), 1);

    // Refill across the pointer wrap, then simultaneous push/pop while full.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(i), 0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 1);
    step(0, 1, 8'h80, 0, 1, 0);
    chk("wrap_count", int'(count), DEPTH);
    chk("wrap_ovf", int'(overflow), 0);
    for (int i = 1; i < DEPTH; i++) step(0, 0, 8'h00, 0, 1, 0);
    chk("wrap_last", int'(dout), 8'h80);
    step(0, 0, 8'h00, 0, 1, 0);

    // Reset with entries held, then a clean write/read.
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h40 + i), 0, 0, 0);
    step(0, 0, 8'h00, 0, 1, 0);
    step(0, 0, 8'h00, 0, 1, 0);
    step(0, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'h50, 0, 0, 0);
    step(0, 1, 8'h51, 0, 0, 0);
    chk("pre_rst_count", int'(count), 5);
    step(1, 1, 8'hEE, 1, 1, 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    step(0, 1, 8'h3C, 0, 0, 0);
    chk("post_rst_data", int'(dout), 8'h3C);
    step(0, 0, 8'h00, 0, 1, 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(99) == 0, $urandom_range(9) < 6, 8'($urandom),
           1'($urandom), $urandom_range(9) < 4, $urandom_range(19) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
